// File: rtl/tff_bank.sv
// rtl/tff_bank.sv - bank of independent ring time-register channels (TFF_BANK_SAT_EN: saturating writes)
module tff_bank #(
    parameter int RING_SEGS = 59,
    parameter int NUM_CH    = 4,
    localparam int PW       = ($clog2(RING_SEGS) < 1) ? 1 : $clog2(RING_SEGS)
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic [NUM_CH-1:0]    we,
    input  logic [NUM_CH-1:0]    re,
    output logic [NUM_CH-1:0]    out,
    output logic [NUM_CH-1:0]    carry,
    output logic [NUM_CH*PW-1:0] pos
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WR   = 2'd1;
    localparam logic [1:0] ST_RD   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [PW-1:0] LAST = PW'(RING_SEGS - 1);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [1:0]    state;
        logic [PW-1:0] pos_r;
        logic [PW-1:0] rd_pos;
        logic [PW-1:0] wr_pos;
        logic          at_top;
        logic          wr_carry;
        logic          out_r;
        logic          carry_r;

        assign at_top = (pos_r == LAST);
        assign rd_pos = at_top ? '0 : pos_r + PW'(1);

`ifdef TFF_BANK_SAT_EN
        // sat_seen limits carry to the first saturating edge of a write burst
        logic sat_seen;

        assign wr_pos   = at_top ? pos_r : pos_r + PW'(1);
        assign wr_carry = at_top & ~sat_seen;

        always_ff @(posedge clk) begin
            if (!rstb || (state == ST_WR && !we[c])) begin
                sat_seen <= 1'b0;
            end else if ((state == ST_IDLE || state == ST_WR) && we[c] && at_top) begin
                sat_seen <= 1'b1;
            end
        end
`else
        assign wr_pos   = rd_pos;
        assign wr_carry = at_top;
`endif

        always_ff @(posedge clk) begin
            if (!rstb) begin
                state   <= ST_IDLE;
                pos_r   <= '0;
                out_r   <= 1'b0;
                carry_r <= 1'b0;
            end else begin
                out_r   <= 1'b0;
                carry_r <= 1'b0;
                case (state)
                    ST_IDLE: begin
                        if (we[c]) begin
                            pos_r   <= wr_pos;
                            carry_r <= wr_carry;
                            state   <= ST_WR;
                        end else if (re[c]) begin
                            // a read started at the top position completes immediately
                            pos_r <= rd_pos;
                            out_r <= at_top;
                            state <= at_top ? ST_DONE : ST_RD;
                        end
                    end
                    ST_WR: begin
                        if (we[c]) begin
                            pos_r   <= wr_pos;
                            carry_r <= wr_carry;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_RD: begin
                        if (re[c]) begin
                            pos_r <= rd_pos;
                            out_r <= at_top;
                            state <= at_top ? ST_DONE : ST_RD;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        if (!re[c]) begin
                            state <= ST_IDLE;
                        end
                    end
                endcase
            end
        end

        assign out[c]           = out_r;
        assign carry[c]         = carry_r;
        assign pos[c*PW +: PW]  = pos_r;
    end

endmodule

// File: doc/tff_bank.md
TFF_BANK -- requirements
Module: tff_bank

Interface
REQ-001 Parameter RING_SEGS, default 59, ring length in clock cycles (legal >= 2).
REQ-002 Parameter NUM_CH, default 4, number of independent time-register channels (legal >= 1).
REQ-003 Derived width PW = max(1, clog2(RING_SEGS)); not overridable.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rstb  input  1  reset, synchronous, active-low.
REQ-006 we  input  NUM_CH  per-channel write enable; each high cycle adds one ring step.
REQ-007 re  input  NUM_CH  per-channel read enable; each high cycle advances the ring toward wrap.
REQ-008 out  output  NUM_CH  per-channel read-complete pulse, registered.
REQ-009 carry  output  NUM_CH  per-channel write-wrap pulse, registered.
REQ-010 pos  output  NUM_CH*PW  per-channel ring position, channel c in bits [c*PW +: PW], registered.

Function
REQ-011 Each channel SHALL hold ring position pos_c in 0..RING_SEGS-1 and a state in {IDLE, WR, RD, DONE}; channels are fully independent.
REQ-012 Step: pos_c <= (pos_c == RING_SEGS-1) ? 0 : pos_c+1; a step where pos_c goes RING_SEGS-1 -> 0 is a "wrap".
REQ-013 IDLE: we_c=1 -> step, go WR; else re_c=1 -> step, go RD; else hold.
REQ-014 IDLE with we_c=1 and re_c=1 in the same cycle: write wins, re_c ignored.
REQ-015 WR: we_c=1 -> step, stay WR; we_c=0 -> no step, go IDLE; re_c ignored in WR.
REQ-016 RD: re_c=1 and step is not a wrap -> step, stay RD; re_c=1 and step is a wrap -> pos_c becomes 0, go DONE; re_c=0 -> no step, go IDLE with pos_c retained (partial read, resumable).
REQ-017 DONE: pos_c held at 0; re_c=1 -> stay DONE with no step; re_c=0 -> IDLE; we_c ignored in DONE.
REQ-018 carry_c SHALL be 1 for exactly the one cycle after a wrap edge taken in IDLE or WR, else 0.
REQ-019 out_c SHALL be 1 for exactly the one cycle after the wrap edge taken in RD, else 0.
REQ-020 Read latency: re_c held from IDLE with stored value v gives out_c high in the cycle after the (RING_SEGS - v)-th re_c high edge; v=0 gives RING_SEGS.
REQ-021 Writes accumulate modulo RING_SEGS across separate we_c bursts, without limit.
REQ-022 pos output SHALL reflect registered pos_c, with no combinational path from we/re to any output.

Reset
REQ-023 Edge with rstb=0: all pos_c=0, state IDLE, out=0, carry=0, regardless of we/re.
REQ-024 Reset mid-WR or mid-RD SHALL abort the operation with no out/carry pulse in the following cycle.
REQ-025 First edge with rstb=1 SHALL evaluate we/re normally from IDLE.

Configuration
REQ-026 Macro TFF_BANK_SAT_EN.
REQ-027 Without it: write steps wrap modulo RING_SEGS per REQ-012/018.
REQ-028 With it: a write step at pos_c = RING_SEGS-1 holds pos_c at RING_SEGS-1.
REQ-029 With it, carry_c pulses once, on the first saturating write edge of each WR burst, and not again until the burst ends.
REQ-030 With it, read behaviour is identical to the macro-absent build.

Verification
REQ-031 Defaults; we0 high 8 cycles, low 1, high 51 cycles -> pos0=0 after burst; carry0 one pulse after the 59th write step; out0 never pulses.
REQ-032 Write 8 to ch0, then re0 held 59 cycles -> out0 pulses once, after the 51st re0 edge; pos0=0; DONE holds until re0 drops.
REQ-033 we1 and re1 asserted together from IDLE for 5 cycles -> pos1=5; out1=0; carry1=0; channels 0, 2, 3 unchanged.
REQ-034 Write 10 to ch2, re2 high 20 cycles, low 1, high 29 -> out2 pulses after the last edge; pos2=0.
REQ-035 rstb=0 on the edge where RD would wrap -> pos=0, out=0 next cycle, state IDLE.
REQ-036 TFF_BANK_SAT_EN build, we3 high 70 cycles -> pos3=58; carry3 exactly one pulse; re3 held 1 cycle -> out3 pulses.
